dcpu16_memsrv: RTL and testbench

Memory responder serving the DCPU16 core's two strobe/acknowledge buses (f_ and g_) from one internal single-port RAM. It sits in place of the dual-port SRAM and free-running ack generator: it arbitrates the two request streams, performs the RAM access, and returns a one-cycle acknowledge with read data after a configurable number of wait states. It is used in the simulation top and in FPGA builds where only single-port block RAM is available.

---
 rtl/dcpu16_memsrv.sv | 83 ++++++++
 tb/tb_dcpu16_memsrv.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dcpu16_memsrv.sv
// dcpu16_memsrv: arbitrated single-port RAM responder for the DCPU16 f/g strobe-ack buses (round-robin arbitration when DCPU16_MEMSRV_RR_EN is defined, fixed f priority otherwise)
module dcpu16_memsrv #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int WS = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   f_adr,
    input  logic [DW-1:0] f_dto,
    input  logic          f_stb,
    input  logic          f_wre,
    output logic          f_ack,
    output logic [DW-1:0] f_dti,
    input  logic [15:0]   g_adr,
    input  logic [DW-1:0] g_dto,
    input  logic          g_stb,
    input  logic          g_wre,
    output logic          g_ack,
    output logic [DW-1:0] g_dti
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    localparam logic [3:0] LOAD = (WS > 0) ? 4'(WS - 1) : 4'd0;
    logic [DW-1:0] bram [0:(1<<AW)-1];
    state_t state, nxt;
    logic [3:0] cnt;
    logic sel, wre_r, f_pend, g_pend, pick_g, grant;
    logic [DW-1:0] rdat, f_hold, g_hold;
    logic [AW-1:0] a;
    assign f_pend = f_stb && !f_ack;
    assign g_pend = g_stb && !g_ack;
    assign grant = (state == IDLE) && (f_pend || g_pend);
    assign a = pick_g ? g_adr[AW-1:0] : f_adr[AW-1:0];
`ifdef DCPU16_MEMSRV_RR_EN
    logic last;
    assign pick_g = g_pend && (!f_pend || !last);
    // remember the last granted port so the other one wins the next conflict
    always_ff @(posedge clk or posedge rst)
        if (rst) last <= 1'b1;
        else if (grant) last <= pick_g;
`else
    assign pick_g = g_pend && !f_pend;
`endif
    // next state: grant in IDLE, count down wait states, single ack cycle
    always_comb begin
        nxt = state;
        nxt = grant ? ((WS > 0) ? WAIT : ACK) :
              (state == WAIT) ? ((cnt == 4'd0) ? ACK : WAIT) :
              (state == ACK) ? IDLE : state;
    end
    // state register, wait counter and latched grant information
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            sel   <= 1'b0;
            wre_r <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= grant ? LOAD : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
            sel   <= grant ? pick_g : sel;
            wre_r <= grant ? (pick_g ? g_wre : f_wre) : wre_r;
        end
    // RAM access happens on the edge ending the grant cycle; bram is never reset
    always_ff @(posedge clk)
        if (grant && !rst) begin
            if (pick_g ? g_wre : f_wre) bram[a] <= pick_g ? g_dto : f_dto;
            else rdat <= bram[a];
        end
    // per-port read data holding registers, refreshed by each read ack
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            f_hold <= '0;
            g_hold <= '0;
        end else begin
            f_hold <= (f_ack && !wre_r) ? rdat : f_hold;
            g_hold <= (g_ack && !wre_r) ? rdat : g_hold;
        end
    assign f_ack = (state == ACK) && !sel;
    assign g_ack = (state == ACK) && sel;
    assign f_dti = (f_ack && !wre_r) ? rdat : f_hold;
    assign g_dti = (g_ack && !wre_r) ? rdat : g_hold;
endmodule

// File: tb/tb_dcpu16_memsrv.sv
// tb_dcpu16_memsrv: scoreboard bench for dcpu16_memsrv with AW=8, WS=2
module tb_dcpu16_memsrv;
    localparam int WS = 2;
    typedef struct { logic [15:0] d; int c; } exp_t;
    logic clk = 0, rst = 1;
    logic [15:0] f_adr = 0, f_dto = 0, g_adr = 0, g_dto = 0;
    logic f_stb = 0, f_wre = 0, g_stb = 0, g_wre = 0;
    logic f_ack, g_ack;
    logic [15:0] f_dti, g_dti;
    int cyc = 0, nvec = 0, nerr = 0, fa = 0, ga = 0;
    exp_t fq[$], gq[$];

    dcpu16_memsrv #(.AW(8), .DW(16), .WS(WS)) dut (
        .clk(clk), .rst(rst),
        .f_adr(f_adr), .f_dto(f_dto), .f_stb(f_stb), .f_wre(f_wre), .f_ack(f_ack), .f_dti(f_dti),
        .g_adr(g_adr), .g_dto(g_dto), .g_stb(g_stb), .g_wre(g_wre), .g_ack(g_ack), .g_dti(g_dti)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every ack pops one expected response and checks data and cycle
    always @(negedge clk) begin
        exp_t e;
        if (f_ack) begin
            fa++;
            nvec++;
            if (fq.size() == 0) begin
                nerr++;
                $display("FAIL f_ack unexpected at cycle %0d dti=%h", cyc, f_dti);
            end else begin
                e = fq.pop_front();
                if (f_dti !== e.d || cyc != e.c) begin
                    nerr++;
                    $display("FAIL f_ack dti=%h cycle=%0d, expected dti=%h cycle=%0d", f_dti, cyc, e.d, e.c);
                end
            end
        end
        if (g_ack) begin
            ga++;
            nvec++;
            if (gq.size() == 0) begin
                nerr++;
                $display("FAIL g_ack unexpected at cycle %0d dti=%h", cyc, g_dti);
            end else begin
                e = gq.pop_front();
                if (g_dti !== e.d || cyc != e.c) begin
                    nerr++;
                    $display("FAIL g_ack dti=%h cycle=%0d, expected dti=%h cycle=%0d", g_dti, cyc, e.d, e.c);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got %h expected %h", n, act, exp);
        end
    endtask

    // single transfer on an idle responder: ack expected 1+WS cycles after the strobe
    task automatic xfer(input bit p, input logic [15:0] a, input bit w, input logic [15:0] d, input logic [15:0] ed);
        int base;
        bit got;
        base = p ? ga : fa;
        if (p) begin
            gq.push_back('{ed, cyc + 1 + WS});
            g_adr = a; g_wre = w; g_dto = d; g_stb = 1;
        end else begin
            fq.push_back('{ed, cyc + 1 + WS});
            f_adr = a; f_wre = w; f_dto = d; f_stb = 1;
        end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = ((p ? ga : fa) != base);
        end
        if (!got) begin
            nvec++;
            nerr++;
            $display("FAIL %s_ack timeout", p ? "g" : "f");
        end
        f_stb = 0;
        g_stb = 0;
        step();
    endtask

    initial begin
        int n, fa0, ga0, ft, gt;
        bit done;
        dut.bram[8'h10] = 16'h1234;
        repeat (3) step();
        chk("reset f_ack", {15'd0, f_ack}, 16'd0);
        chk("reset g_ack", {15'd0, g_ack}, 16'd0);
        chk("reset f_dti", f_dti, 16'd0);
        chk("reset g_dti", g_dti, 16'd0);
        rst = 0;
        step();
        xfer(0, 16'h0010, 0, 16'h0000, 16'h1234);
        xfer(1, 16'h0010, 0, 16'h0000, 16'h1234);
        xfer(1, 16'h0020, 1, 16'hBEEF, 16'h1234);
        xfer(0, 16'h0020, 0, 16'h0000, 16'hBEEF);
        xfer(0, 16'h0105, 1, 16'h5555, 16'hBEEF);
        xfer(1, 16'h0005, 0, 16'h0000, 16'h5555);
        n = cyc;
        fa0 = fa;
        ga0 = ga;
`ifdef DCPU16_MEMSRV_RR_EN
        ft = 3;
        gt = 3;
        for (int k = 0; k < 3; k++) begin
            fq.push_back('{16'h1234, n + 3 + 8 * k});
            gq.push_back('{16'hBEEF, n + 7 + 8 * k});
        end
`else
        ft = 6;
        gt = 1;
        for (int k = 0; k < 6; k++) fq.push_back('{16'h1234, n + 3 + 4 * k});
        gq.push_back('{16'hBEEF, n + 27});
`endif
        f_adr = 16'h0010; f_wre = 0; f_stb = 1;
        g_adr = 16'h0020; g_wre = 0; g_stb = 1;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            if (fa - fa0 >= ft) f_stb = 0;
            if (ga - ga0 >= gt) g_stb = 0;
            done = (fa - fa0 >= ft) && (ga - ga0 >= gt);
        end
        if (!done) begin
            nvec++;
            nerr++;
            $display("FAIL conflict timeout f=%0d g=%0d", fa - fa0, ga - ga0);
        end
        f_stb = 0;
        g_stb = 0;
        step();
        f_adr = 16'h0010; f_wre = 0; f_stb = 1;
        step();
        step();
        rst = 1;
        f_stb = 0;
        step();
        rst = 0;
        chk("post-reset f_ack", {15'd0, f_ack}, 16'd0);
        chk("post-reset f_dti", f_dti, 16'd0);
        chk("post-reset g_dti", g_dti, 16'd0);
        repeat (6) step();
        xfer(0, 16'h0020, 0, 16'h0000, 16'hBEEF);
        repeat (5) step();
        nvec++;
        if (fq.size() != 0 || gq.size() != 0) begin
            nerr++;
            $display("FAIL missing acks f=%0d g=%0d expected 0 0", fq.size(), gq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
